// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between instruction fetch (IF) and
// load/store data (D). Data requests win arbitration; a starvation counter
// forces a pending fetch through after STARVE_MAX consecutive losses. Each
// access holds the memory strobe for MEM_LAT cycles, then spends one DONE
// cycle pulsing the winner's acknowledge. busy is the CPU stall source.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   if_req/if_addr                  fetch request and address
//   if_rdata/if_ack                 fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata       data request (d_we=1 store, 0 load)
//   d_rdata/d_ack                   load data and completion pulse
//   mem_addr/mem_wdata              memory address / write data
//   mem_rd/mem_wr                   memory read / write strobes
//   mem_rdata                       memory read data (valid last ACCESS cycle)
//   busy                            high in ACCESS and DONE
//   if_grant_cnt/d_grant_cnt        saturating grant counters
//
// Build option: define ARB_STATS_EN to build the grant counters; otherwise
// both counter ports are tied to zero.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [15:0]   if_grant_cnt,
  output logic [15:0]   d_grant_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t          state_q, state_d;
  logic [3:0]      lat_q, lat_d;
  logic [3:0]      starve_q, starve_d;
  logic            sel_if_q, sel_if_d;   // winner of the current access
  logic            we_q, we_d;           // current access is a store
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            busy_q, busy_d;
  logic            grant_if, grant_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    lat_d       = lat_q;
    sel_if_d    = sel_if_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    busy_d      = busy_q;
    grant_if    = 1'b0;
    grant_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Data wins a tie unless fetch has already lost STARVE_MAX times.
        if (if_req && (!d_req || starve_q == STARVE_LIM)) grant_if = 1'b1;
        else if (d_req)                                   grant_d  = 1'b1;

        if (grant_if || grant_d) begin
          state_d     = S_ACCESS;
          lat_d       = 4'd0;
          sel_if_d    = grant_if;
          we_d        = grant_d & d_we;
          mem_addr_d  = grant_if ? if_addr : d_addr;
          mem_wdata_d = grant_if ? '0 : d_wdata;
          mem_rd_d    = ~(grant_d & d_we);
          mem_wr_d    = grant_d & d_we;
          busy_d      = 1'b1;
        end
      end

      S_ACCESS: begin
        if (lat_q == LAT_LAST) begin
          state_d  = S_DONE;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (sel_if_q)   if_rdata_d = mem_rdata;
          else if (!we_q) d_rdata_d  = mem_rdata;
          if_ack_d = sel_if_q;
          d_ack_d  = ~sel_if_q;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      S_DONE: begin
        // Requests are deliberately not sampled here: the requester is
        // still seeing its ack and may not have updated its request yet.
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    // Starvation only counts real arbitration losses while fetch waits.
    if (!if_req || grant_if)                  starve_d = 4'd0;
    else if (grant_d && starve_q < STARVE_LIM) starve_d = starve_q + 4'd1;
    else                                      starve_d = starve_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_q       <= 4'd0;
      starve_q    <= 4'd0;
      sel_if_q    <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      sel_if_q    <= sel_if_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;

`ifdef ARB_STATS_EN
  logic [15:0] if_cnt_q, if_cnt_d;
  logic [15:0] d_cnt_q, d_cnt_d;

  always_comb begin
    if_cnt_d = if_cnt_q;
    d_cnt_d  = d_cnt_q;
    if (grant_if && if_cnt_q != 16'hFFFF) if_cnt_d = if_cnt_q + 16'd1;
    if (grant_d  && d_cnt_q  != 16'hFFFF) d_cnt_d  = d_cnt_q  + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_cnt_q <= 16'h0000;
      d_cnt_q  <= 16'h0000;
    end else begin
      if_cnt_q <= if_cnt_d;
      d_cnt_q  <= d_cnt_d;
    end
  end

  assign if_grant_cnt = if_cnt_q;
  assign d_grant_cnt  = d_cnt_q;
`else
  assign if_grant_cnt = 16'h0000;
  assign d_grant_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter at MEM_LAT=2, STARVE_MAX=4. A small
// memory model answers reads combinationally from written words or a fixed
// pattern; inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [15:0]   if_grant_cnt;
  logic [15:0]   d_grant_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy),
    .if_grant_cnt(if_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  // Memory model: unwritten words return a fixed pattern.
  bit [31:0] ram [256];
  bit        wrt [256];

  function automatic logic [31:0] rom_word(input logic [7:0] idx);
    return (idx == 8'd4) ? 32'h2008_0005 : (32'hA000_0000 | {24'h0, idx});
  endfunction

  assign mem_rdata = !mem_rd ? '0 :
                     (wrt[mem_addr[9:2]] ? ram[mem_addr[9:2]] : rom_word(mem_addr[9:2]));

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_addr[9:2]] <= mem_wdata;
      wrt[mem_addr[9:2]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete access; starts and ends on a falling edge, request dropped
  // in the ack cycle. lat counts falling edges from request to ack.
  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        output int lat, output int rd_cyc, output int wr_cyc);
    bit done = 0;
    lat = 0; rd_cyc = 0; wr_cyc = 0;
    @(negedge clk);
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    else begin if_req = 1'b1; if_addr = addr; end
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_rd) rd_cyc++;
      if (mem_wr) wr_cyc++;
      if ((is_d && d_ack) || (!is_d && if_ack)) done = 1;
    end
    if_req = 1'b0; d_req = 1'b0;
    if (!done) check("access_timeout", 0, 1);
  endtask

  int       lat, rdc, wrc, n_ack, k, last;
  logic [9:0] got_ord;
  bit       both_seen, ack_in_rst;

  initial begin
    // Reset state
    #2;
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_strobes", {mem_rd, mem_wr}, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cnt", {if_grant_cnt, d_grant_cnt}, 0);
    @(negedge clk); rst = 1'b0;

    // Single fetch, cycle by cycle
    @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0010;
    @(negedge clk);
    check("f1_c1_rd", {mem_rd, mem_wr}, 2'b10);
    check("f1_c1_addr", mem_addr, 32'h10);
    check("f1_c1_busy_ack", {busy, if_ack}, 2'b10);
    @(negedge clk);
    check("f1_c2_rd_ack", {mem_rd, if_ack}, 2'b10);
    @(negedge clk);
    check("f1_c3_acks", {if_ack, d_ack}, 2'b10);
    check("f1_c3_strobes", {mem_rd, mem_wr}, 0);
    check("f1_c3_addr_hold", mem_addr, 32'h10);
    check("f1_c3_rdata", if_rdata, 32'h2008_0005);
    check("f1_c3_busy", busy, 1);
    if_req = 1'b0;
    @(negedge clk);
    check("f1_c4_ack_busy", {if_ack, busy}, 0);
    check("f1_c4_rdata_hold", if_rdata, 32'h2008_0005);

    // Store then load, then another store
    access(1, 1, 32'h40, 32'hDEAD_BEEF, lat, rdc, wrc);
    check("st_lat", lat, 3);
    check("st_strobes", {rdc[7:0], wrc[7:0]}, {8'd0, 8'd2});
    check("st_d_rdata_unchanged", d_rdata, 0);
    access(1, 0, 32'h40, 32'h0, lat, rdc, wrc);
    check("ld_lat", lat, 3);
    check("ld_strobes", {rdc[7:0], wrc[7:0]}, {8'd2, 8'd0});
    check("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);
    access(1, 1, 32'h44, 32'h1234_5678, lat, rdc, wrc);
    check("st2_d_rdata_hold", d_rdata, 32'hDEAD_BEEF);

    // Simultaneous requests held high: D,D,D,D,IF,D,D,D,D,IF
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    n_ack = 0; got_ord = '0; both_seen = 0;
    for (int cyc = 0; cyc < 80 && n_ack < 10; cyc++) begin
      @(negedge clk);
      if (if_ack && d_ack) both_seen = 1;
      if (d_ack)       begin got_ord[n_ack] = 1'b1; n_ack++; end
      else if (if_ack) begin got_ord[n_ack] = 1'b0; n_ack++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    check("arb_ack_count", n_ack, 10);
    check("arb_order", got_ord, 10'h1EF);
    check("arb_no_double_ack", both_seen, 0);
    check("arb_if_rdata", if_rdata, 32'hA000_0040);
    check("arb_d_rdata", d_rdata, 32'hA000_0041);

    // Reset during the first ACCESS cycle of a fetch
    @(negedge clk); if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("rm_pre_rd", mem_rd, 1);
    #1 rst = 1'b1;
    #1;
    check("rm_strobes", {mem_rd, mem_wr}, 0);
    check("rm_busy_ack", {busy, if_ack}, 0);
    check("rm_rdata_cleared", {if_rdata, d_rdata}, 0);
    if_req = 1'b0;
    ack_in_rst = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_ack) ack_in_rst = 1;
    end
    check("rm_no_ack", ack_in_rst, 0);
    rst = 1'b0;
    access(0, 0, 32'h10, 32'h0, lat, rdc, wrc);
    check("rm_after_lat", lat, 3);
    check("rm_after_rdata", if_rdata, 32'h2008_0005);

    // Back-to-back fetches after a fresh reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h20;
    k = 0; last = 0;
    for (int cyc = 1; cyc <= 40 && k < 3; cyc++) begin
      @(negedge clk);
      if (if_ack) begin
        check("b2b_rdata", if_rdata, rom_word(if_addr[9:2]));
        if (k == 0) check("b2b_first_lat", cyc, 3);
        else        check("b2b_spacing", cyc - last, 4);
        last = cyc;
        k++;
        if_addr = if_addr + 32'd4;
        if (k == 3) if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    check("b2b_count", k, 3);

    // Two data accesses, then grant statistics
    access(1, 1, 32'h80, 32'hCAFE_F00D, lat, rdc, wrc);
    access(1, 0, 32'h80, 32'h0, lat, rdc, wrc);
    check("sd_ld_rdata", d_rdata, 32'hCAFE_F00D);
`ifdef ARB_STATS_EN
    check("stats_if_cnt", if_grant_cnt, 16'd3);
    check("stats_d_cnt", d_grant_cnt, 16'd2);
`else
    check("stats_if_cnt", if_grant_cnt, 16'd0);
    check("stats_d_cnt", d_grant_cnt, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
